data_mem_arbiter: RTL

//  Shares the single-port data memory between two requesters:
//   - port 0: the rv32i core load/store path.
//   - port 1: a loader/debug master that preloads and inspects memory.

---
 rtl/data_mem_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port data memory between two requesters. Port 0 is the
//   core load/store path and port 1 is the loader/debug master. Each request
//   uses a valid/ready handshake, and the arbiter grants requests round-robin.
//   Only one transaction is in flight at a time. The memory is driven from
//   fields that were registered when the request was accepted.
//
// Ports
//   clk_i, rst_ni                   clock (rising edge), async active-low reset
//   valid{0,1}_i, we{0,1}_i         request valid / write select per port
//   addr{0,1}_i, wdata{0,1}_i       word address / write data per port
//   wstrb{0,1}_i                    byte enables (ignored on reads)
//   ready{0,1}_o                    request accepted this cycle
//   rvalid{0,1}_o, rdata{0,1}_o     one-cycle completion pulse / read data
//   mem_en_o, mem_we_o              memory access strobe / write enable
//   mem_addr_o, mem_wdata_o         memory address / write data
//   mem_wstrb_o, mem_rdata_i        memory byte enables / read data
//
// MEM_LAT is the memory read latency in cycles after the mem_en cycle (1..4).
module data_mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid0_i,
    input  logic                we0_i,
    input  logic [ADDR_W-1:0]   addr0_i,
    input  logic [DATA_W-1:0]   wdata0_i,
    input  logic [DATA_W/8-1:0] wstrb0_i,
    input  logic                valid1_i,
    input  logic                we1_i,
    input  logic [ADDR_W-1:0]   addr1_i,
    input  logic [DATA_W-1:0]   wdata1_i,
    input  logic [DATA_W/8-1:0] wstrb1_i,
    output logic                ready0_o,
    output logic                ready1_o,
    output logic                rvalid0_o,
    output logic                rvalid1_o,
    output logic [DATA_W-1:0]   rdata0_o,
    output logic [DATA_W-1:0]   rdata1_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int SW    = DATA_W / 8;
    localparam int LAT_W = 2;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    state_t            state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic winner;
    logic accept;

    // A lone requester wins outright. On a tie, the port that did not win
    // last time gets the grant.
    always_comb begin
        if (valid0_i && valid1_i) winner = ~rr_last_q;
        else                      winner = valid1_i;
    end

    // ready is gated by rst_ni so that it also drops asynchronously during reset.
    assign accept   = rst_ni && (state_q == IDLE) && (valid0_i || valid1_i);
    assign ready0_o = accept && !winner;
    assign ready1_o = accept && winner;

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        port_d    = port_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        lat_cnt_d = lat_cnt_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    port_d    = winner;
                    rr_last_d = winner;
                    we_d      = winner ? we1_i    : we0_i;
                    addr_d    = winner ? addr1_i  : addr0_i;
                    wdata_d   = winner ? wdata1_i : wdata0_i;
                    wstrb_d   = winner ? wstrb1_i : wstrb0_i;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    // A write completes without waiting for the memory.
                    state_d = IDLE;
                    if (port_q) rvalid1_d = 1'b1;
                    else        rvalid0_d = 1'b1;
                end else begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = IDLE;
                    if (port_q) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = mem_rdata_i;
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = mem_rdata_i;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            lat_cnt_q <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            port_q    <= port_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            lat_cnt_q <= lat_cnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // Address and write data come straight from the latched fields. They only
    // change on acceptance, so they hold their last value while mem_en is low.
    assign mem_en_o    = (state_q == ACCESS);
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_wstrb_o = mem_we_o ? wstrb_q : '0;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rvalid0_o   = rvalid0_q;
    assign rvalid1_o   = rvalid1_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;

endmodule
